// File: rtl/digital_integ_pkg.sv
// digital_integ_pkg: shared defaults, saturation bounds and sign-extension helper for the integrator
package digital_integ_pkg;
  localparam int DEF_IN_W = 8;
  localparam int DEF_ACC_W = 16;
  localparam int DEF_LEAK_SHIFT = 0;
  localparam int DEF_CNT_W = 16;
  function automatic longint acc_max(int w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction
  function automatic longint acc_min(int w);
    return -(longint'(1) <<< (w - 1));
  endfunction
  function automatic longint sext(longint v, int w);
    return (v <<< (64 - w)) >>> (64 - w);
  endfunction
endpackage

// File: rtl/digital_integ_sat_add.sv
// sat_add: acc + sext(diff) - leak, clamped to the ACC_W signed range
//   i_acc    : current accumulator (signed ACC_W)
//   i_diff   : difference sample (signed IN_W)
//   o_result : clamped next accumulator
//   o_ovf    : high when the clamp was applied
module sat_add
  import digital_integ_pkg::*;
#(
  parameter int IN_W = DEF_IN_W,
  parameter int ACC_W = DEF_ACC_W,
  parameter int LEAK_SHIFT = DEF_LEAK_SHIFT
) (
  input  logic signed [ACC_W-1:0] i_acc,
  input  logic signed [IN_W-1:0]  i_diff,
  output logic signed [ACC_W-1:0] o_result,
  output logic                    o_ovf
);
  localparam int SW = ACC_W + 2;
  localparam logic signed [SW-1:0] MAX = SW'(acc_max(ACC_W));
  localparam logic signed [SW-1:0] MIN = SW'(acc_min(ACC_W));
  logic signed [SW-1:0] w_acc, w_diff, w_leak, w_sum;
  logic w_hi, w_lo;
  assign w_acc = SW'(i_acc);
  assign w_diff = SW'(sext(longint'($unsigned(i_diff)), IN_W));
  assign w_leak = (LEAK_SHIFT == 0) ? '0 : (w_acc >>> LEAK_SHIFT);
  assign w_sum = w_acc + w_diff - w_leak;
  assign w_hi = w_sum > MAX;
  assign w_lo = w_sum < MIN;
  assign o_ovf = w_hi || w_lo;
  assign o_result = w_hi ? MAX[ACC_W-1:0] : w_lo ? MIN[ACC_W-1:0] : w_sum[ACC_W-1:0];
endmodule

// File: rtl/digital_integ.sv
// digital_integ: saturating leaky integrator with valid/ready on both sides
//   clear                          : sync flush of level, counter and flags (beats accept/consume)
//   diff_in/in_valid/in_ready      : signed difference sample input
//   level_out/out_valid/out_ready  : registered integrated level output
//   sat                            : sticky saturation flag
//   sample_cnt                     : accepted samples since reset/clear (wraps)
module digital_integ
  import digital_integ_pkg::*;
#(
  parameter int IN_W = DEF_IN_W,
  parameter int ACC_W = DEF_ACC_W,
  parameter int LEAK_SHIFT = DEF_LEAK_SHIFT,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic signed [IN_W-1:0]  diff_in,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic signed [ACC_W-1:0] level_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sat,
  output logic [CNT_W-1:0]        sample_cnt
);
  // the accumulator and the output register always hold the same value, so one register serves both
  logic signed [ACC_W-1:0] r_acc, w_next;
  logic r_out_valid, r_sat, w_ovf, w_accept;
  logic [CNT_W-1:0] r_cnt;
  sat_add #(.IN_W(IN_W), .ACC_W(ACC_W), .LEAK_SHIFT(LEAK_SHIFT)) u_sat_add (
    .i_acc(r_acc),
    .i_diff(diff_in),
    .o_result(w_next),
    .o_ovf(w_ovf)
  );
  assign in_ready = !clear && (!r_out_valid || out_ready);
  assign w_accept = in_valid && in_ready;
  always_ff @(posedge clk or posedge rst) begin
    if (rst || clear) begin
      r_acc <= '0;
      r_out_valid <= 1'b0;
      r_sat <= 1'b0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_acc <= w_next;
      r_out_valid <= 1'b1;
      r_sat <= r_sat | w_ovf;
      r_cnt <= r_cnt + 1'b1;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end
  assign level_out = r_acc;
  assign out_valid = r_out_valid;
  assign sat = r_sat;
  assign sample_cnt = r_cnt;
endmodule

// File: tb/tb_digital_integ.sv
// tb_digital_integ: vector table, random walk against a reference model, directed saturation/leak/reset cases
module tb_digital_integ;
  logic clk = 1'b0;
  logic rst, clear, in_valid, out_ready, in_ready, out_valid, sat;
  logic signed [7:0] diff_in;
  logic signed [15:0] level_out;
  logic [15:0] sample_cnt;
  logic l_clear, l_valid, l_ordy, l_iready, l_ov, l_sat;
  logic signed [7:0] l_diff;
  logic signed [15:0] l_level;
  logic [15:0] l_cnt;
  int n_cmp = 0, n_bad = 0;
  int m_lvl, m_cnt;
  bit m_ov, m_sat;
  typedef struct {
    bit clr; bit vld; int d; bit ordy;
    int lvl; bit ov; bit st; int cnt;
  } vec_t;
  vec_t tbl[$];

  digital_integ dut (
    .clk(clk), .rst(rst), .clear(clear), .diff_in(diff_in), .in_valid(in_valid),
    .in_ready(in_ready), .level_out(level_out), .out_valid(out_valid),
    .out_ready(out_ready), .sat(sat), .sample_cnt(sample_cnt)
  );
  digital_integ #(.LEAK_SHIFT(2)) dut_leak (
    .clk(clk), .rst(rst), .clear(l_clear), .diff_in(l_diff), .in_valid(l_valid),
    .in_ready(l_iready), .level_out(l_level), .out_valid(l_ov),
    .out_ready(l_ordy), .sat(l_sat), .sample_cnt(l_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_lvl = 0; m_cnt = 0; m_ov = 0; m_sat = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; clear = 0; in_valid = 0; out_ready = 1; diff_in = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  // drives one cycle, checks in_ready, advances the model with saturation as plain integer arithmetic
  task automatic apply(input bit clr, input bit vld, input int d, input bit ordy);
    bit rdy, acc;
    int s;
    clear = clr; in_valid = vld; diff_in = 8'(d); out_ready = ordy;
    #1;
    rdy = !clr && (!m_ov || ordy);
    chk("in_ready", in_ready, rdy);
    acc = vld && rdy;
    @(posedge clk); #1;
    if (clr) model_reset();
    else if (acc) begin
      s = m_lvl + d;
      if (s > 32767) begin s = 32767; m_sat = 1; end
      if (s < -32768) begin s = -32768; m_sat = 1; end
      m_lvl = s; m_ov = 1; m_cnt = (m_cnt + 1) % 65536;
    end else if (ordy) m_ov = 0;
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, " level_out"}, level_out, m_lvl);
    chk({tag, " out_valid"}, out_valid, m_ov);
    chk({tag, " sat"}, sat, m_sat);
    chk({tag, " sample_cnt"}, sample_cnt, m_cnt);
  endtask

  initial begin
    rst = 1'b1; clear = 0; in_valid = 0; out_ready = 1; diff_in = 0;
    l_clear = 0; l_valid = 0; l_ordy = 1; l_diff = 0;
    #2;
    chk("reset level_out", level_out, 0);
    chk("reset out_valid", out_valid, 0);
    chk("reset sample_cnt", sample_cnt, 0);
    do_reset();
    chk("in_ready after reset", in_ready, 1);

    // ramp, backpressure, then clear with in_valid high at level 40
    tbl.push_back('{0,1,3,1,   3,1,0,1});
    tbl.push_back('{0,1,3,1,   6,1,0,2});
    tbl.push_back('{0,1,3,1,   9,1,0,3});
    tbl.push_back('{0,1,3,1,  12,1,0,4});
    tbl.push_back('{0,1,3,1,  15,1,0,5});
    tbl.push_back('{0,1,3,1,  18,1,0,6});
    tbl.push_back('{0,1,5,0,  18,1,0,6});
    tbl.push_back('{0,1,5,0,  18,1,0,6});
    tbl.push_back('{0,1,5,1,  23,1,0,7});
    tbl.push_back('{0,0,0,1,  23,0,0,7});
    tbl.push_back('{0,1,17,1, 40,1,0,8});
    tbl.push_back('{1,1,9,1,   0,0,0,0});
    tbl.push_back('{0,0,0,0,   0,0,0,0});
    foreach (tbl[i]) begin
      apply(tbl[i].clr, tbl[i].vld, tbl[i].d, tbl[i].ordy);
      chk($sformatf("vec%0d level_out", i), level_out, tbl[i].lvl);
      chk($sformatf("vec%0d out_valid", i), out_valid, tbl[i].ov);
      chk($sformatf("vec%0d sat", i), sat, tbl[i].st);
      chk($sformatf("vec%0d sample_cnt", i), sample_cnt, tbl[i].cnt);
    end

    // positive saturation: preload to 32760 = 257*127 + 121
    do_reset();
    for (int i = 0; i < 257; i++) apply(0, 1, 127, 1);
    apply(0, 1, 121, 1);
    chk("preload level", level_out, 32760);
    apply(0, 1, 100, 1);
    chk("pos sat level", level_out, 32767);
    chk("pos sat flag", sat, 1);
    apply(0, 1, -7, 1);
    chk("after sat level", level_out, 32760);
    chk("sat sticky", sat, 1);
    cmp_model("possat");

    // negative saturation: 256 * -128 lands exactly on the bound without clamping
    do_reset();
    for (int i = 0; i < 256; i++) apply(0, 1, -128, 1);
    chk("neg bound level", level_out, -32768);
    chk("neg bound no sat", sat, 0);
    apply(0, 1, -128, 1);
    apply(0, 1, -128, 1);
    chk("neg hold level", level_out, -32768);
    chk("neg sat flag", sat, 1);
    cmp_model("negsat");

    // random walk against the model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      apply($urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7,
            int'($urandom_range(0, 255)) - 128, $urandom_range(0, 9) < 6);
      cmp_model("rand");
    end

    // leak with LEAK_SHIFT = 2: 64, 64-16=48, 48-12=36
    l_valid = 1; l_diff = 64;
    @(posedge clk); #1;
    chk("leak 1", l_level, 64);
    l_diff = 0;
    @(posedge clk); #1;
    chk("leak 2", l_level, 48);
    @(posedge clk); #1;
    chk("leak 3", l_level, 36);
    chk("leak cnt", l_cnt, 3);
    l_valid = 0;

    // reset mid-stream, asserted between edges
    apply(0, 1, 50, 0);
    #2 rst = 1'b1;
    #1;
    chk("midrst level_out", level_out, 0);
    chk("midrst out_valid", out_valid, 0);
    chk("midrst sample_cnt", sample_cnt, 0);
    chk("midrst leak level", l_level, 0);
    chk("midrst leak valid", l_ov, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    apply(0, 1, 7, 1);
    cmp_model("post rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
